// File: rtl/sw_input_conditioner.sv
// sw_input_conditioner: turns raw, bouncing board switches into the
// processor's SW_in bus. Each bit passes through a two-flop synchronizer.
// One debounce FSM and counter watch the whole vector. A value is committed
// to SW_out only after it has been stable for DEBOUNCE_CYCLES clocks. Each
// commit raises a sticky change event that the processor clears with SW_ack.
module sw_input_conditioner #(
  parameter int unsigned WIDTH           = 5,
  parameter int unsigned DEBOUNCE_CYCLES = 16,
  parameter int unsigned CNT_W           = 8
) (
  input  logic             Clock,
  input  logic             Resetn,
  input  logic [WIDTH-1:0] SW_raw,
  input  logic             SW_ack,
  output logic [WIDTH-1:0] SW_out,
  output logic             SW_valid,
  output logic [WIDTH-1:0] SW_changed
);

  typedef enum logic {
    ST_STABLE = 1'b0,
    ST_SETTLE = 1'b1
  } state_t;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  state_t           r_state;
  logic [WIDTH-1:0] r_sync1;
  logic [WIDTH-1:0] r_sync2;
  logic [WIDTH-1:0] r_cand;
  logic [CNT_W-1:0] r_cnt;
  logic [WIDTH-1:0] r_out;
  logic             r_valid;
  logic [WIDTH-1:0] r_changed;

  logic             w_commit;
  logic [WIDTH-1:0] w_keep_mask;

  // Commit decision and the part of the old change mask that survives it.
  // An ack in the same cycle consumes the old mask; the new delta still lands.
  always_comb begin
    w_commit    = (r_state == ST_SETTLE) && (r_sync2 == r_cand) && (r_cnt == CNT_LAST);
    w_keep_mask = (r_valid && !SW_ack) ? r_changed : '0;
  end

  // Synchronizer, debounce FSM and change-event register.
  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      r_sync1   <= '0;
      r_sync2   <= '0;
      r_cand    <= '0;
      r_cnt     <= '0;
      r_out     <= '0;
      r_valid   <= 1'b0;
      r_changed <= '0;
      r_state   <= ST_STABLE;
    end else begin
      r_sync1 <= SW_raw;
      r_sync2 <= r_sync1;

      case (r_state)
        ST_STABLE: begin
          if (r_sync2 != r_out) begin
            r_cand  <= r_sync2;
            r_cnt   <= '0;
            r_state <= ST_SETTLE;
          end
        end
        ST_SETTLE: begin
          if (r_sync2 == r_cand) begin
            if (r_cnt == CNT_LAST) begin
              r_out   <= r_cand;
              r_cnt   <= '0;
              r_state <= ST_STABLE;
            end else begin
              r_cnt <= r_cnt + 1'b1;
            end
          end else if (r_sync2 == r_out) begin
            r_cnt   <= '0;
            r_state <= ST_STABLE;
          end else begin
            r_cand <= r_sync2;
            r_cnt  <= '0;
          end
        end
        default: begin
          r_cnt   <= '0;
          r_state <= ST_STABLE;
        end
      endcase

      if (w_commit) begin
        r_valid   <= 1'b1;
        r_changed <= w_keep_mask | (r_out ^ r_cand);
      end else if (SW_ack && r_valid) begin
        r_valid   <= 1'b0;
        r_changed <= '0;
      end
    end
  end

  assign SW_out     = r_out;
  assign SW_valid   = r_valid;
  assign SW_changed = r_changed;

endmodule

// File: tb/tb_sw_input_conditioner.sv
// Directed bench for sw_input_conditioner with DEBOUNCE_CYCLES=4.
// Inputs are driven 1 time unit after a rising edge, so the next edge is E0.
// Outputs are sampled 1 time unit after each edge.
module tb_sw_input_conditioner;

  localparam int unsigned W  = 5;
  localparam int unsigned DC = 4;

  logic         Clock;
  logic         Resetn;
  logic [W-1:0] SW_raw;
  logic         SW_ack;
  logic [W-1:0] SW_out;
  logic         SW_valid;
  logic [W-1:0] SW_changed;

  int n_total;
  int n_bad;

  sw_input_conditioner #(
    .WIDTH(W),
    .DEBOUNCE_CYCLES(DC),
    .CNT_W(8)
  ) dut (
    .Clock(Clock),
    .Resetn(Resetn),
    .SW_raw(SW_raw),
    .SW_ack(SW_ack),
    .SW_out(SW_out),
    .SW_valid(SW_valid),
    .SW_changed(SW_changed)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  task automatic edge1();
    @(posedge Clock);
    #1;
  endtask

  // Hold reset for two edges with SW_raw = v, then release.
  task automatic do_reset(input logic [W-1:0] v);
    SW_ack = 1'b0;
    SW_raw = v;
    Resetn = 1'b0;
    edge1();
    edge1();
    Resetn = 1'b1;
  endtask

  task automatic test_reset();
    do_reset('0);
    for (int i = 0; i < 20; i++) begin
      edge1();
      n_total++;
      if (SW_out !== 5'b0 || SW_valid !== 1'b0 || SW_changed !== 5'b0) begin
        n_bad++;
        $display("FAIL reset_idle cyc=%0d got out=%b valid=%b chg=%b want 00000/0/00000",
                 i, SW_out, SW_valid, SW_changed);
      end
    end
  endtask

  task automatic test_basic_commit();
    do_reset('0);
    edge1();
    SW_raw = 5'b00101;
    for (int i = 0; i < 6; i++) begin
      edge1();
      n_total++;
      if (SW_valid !== 1'b0 || SW_out !== 5'b0) begin
        n_bad++;
        $display("FAIL basic_early E%0d got out=%b valid=%b want 00000/0", i, SW_out, SW_valid);
      end
    end
    edge1();
    n_total++;
    if (SW_out !== 5'b00101 || SW_valid !== 1'b1 || SW_changed !== 5'b00101) begin
      n_bad++;
      $display("FAIL basic_commit got out=%b valid=%b chg=%b want 00101/1/00101",
               SW_out, SW_valid, SW_changed);
    end
    SW_ack = 1'b1;
    edge1();
    SW_ack = 1'b0;
    n_total++;
    if (SW_valid !== 1'b0 || SW_changed !== 5'b0 || SW_out !== 5'b00101) begin
      n_bad++;
      $display("FAIL basic_ack got out=%b valid=%b chg=%b want 00101/0/00000",
               SW_out, SW_valid, SW_changed);
    end
  endtask

  task automatic test_bounce_low();
    do_reset('0);
    edge1();
    SW_raw = 5'b00001; edge1();
    SW_raw = 5'b00000; edge1();
    SW_raw = 5'b00001; edge1();
    SW_raw = 5'b00000;
    for (int i = 0; i < 15; i++) begin
      edge1();
      n_total++;
      if (SW_valid !== 1'b0 || SW_out !== 5'b0) begin
        n_bad++;
        $display("FAIL bounce_low cyc=%0d got out=%b valid=%b want 00000/0", i, SW_out, SW_valid);
      end
    end
  endtask

  // Ends high, and leaves SW_out=00001 / SW_valid=1 for test_accumulate.
  task automatic test_bounce_high();
    do_reset('0);
    edge1();
    SW_raw = 5'b00001; edge1();
    SW_raw = 5'b00000; edge1();
    SW_raw = 5'b00001; edge1();
    SW_raw = 5'b00000; edge1();
    SW_raw = 5'b00001;
    for (int i = 0; i < 6; i++) begin
      edge1();
      n_total++;
      if (SW_valid !== 1'b0) begin
        n_bad++;
        $display("FAIL bounce_high_early E%0d got valid=%b want 0", i, SW_valid);
      end
    end
    edge1();
    n_total++;
    if (SW_out !== 5'b00001 || SW_valid !== 1'b1 || SW_changed !== 5'b00001) begin
      n_bad++;
      $display("FAIL bounce_high_commit got out=%b valid=%b chg=%b want 00001/1/00001",
               SW_out, SW_valid, SW_changed);
    end
    for (int i = 0; i < 5; i++) begin
      edge1();
      n_total++;
      if (SW_out !== 5'b00001 || SW_valid !== 1'b1) begin
        n_bad++;
        $display("FAIL bounce_high_single cyc=%0d got out=%b valid=%b want 00001/1",
                 i, SW_out, SW_valid);
      end
    end
  endtask

  task automatic test_accumulate();
    SW_raw = 5'b10001;
    for (int i = 0; i < 6; i++) begin
      edge1();
      n_total++;
      if (SW_valid !== 1'b1 || SW_out !== 5'b00001 || SW_changed !== 5'b00001) begin
        n_bad++;
        $display("FAIL accum_hold E%0d got out=%b valid=%b chg=%b want 00001/1/00001",
                 i, SW_out, SW_valid, SW_changed);
      end
    end
    edge1();
    n_total++;
    if (SW_out !== 5'b10001 || SW_valid !== 1'b1 || SW_changed !== 5'b10001) begin
      n_bad++;
      $display("FAIL accum_commit got out=%b valid=%b chg=%b want 10001/1/10001",
               SW_out, SW_valid, SW_changed);
    end
  endtask

  task automatic test_collision();
    do_reset('0);
    edge1();
    SW_raw = 5'b00001;
    repeat (7) edge1();
    n_total++;
    if (SW_out !== 5'b00001 || SW_valid !== 1'b1) begin
      n_bad++;
      $display("FAIL coll_first got out=%b valid=%b want 00001/1", SW_out, SW_valid);
    end
    SW_raw = 5'b10001;
    repeat (6) edge1();
    SW_ack = 1'b1;
    edge1();
    SW_ack = 1'b0;
    n_total++;
    if (SW_out !== 5'b10001 || SW_valid !== 1'b1 || SW_changed !== 5'b10000) begin
      n_bad++;
      $display("FAIL coll_commit got out=%b valid=%b chg=%b want 10001/1/10000",
               SW_out, SW_valid, SW_changed);
    end
    SW_ack = 1'b1;
    edge1();
    SW_ack = 1'b0;
    n_total++;
    if (SW_valid !== 1'b0 || SW_changed !== 5'b0) begin
      n_bad++;
      $display("FAIL coll_ack got valid=%b chg=%b want 0/00000", SW_valid, SW_changed);
    end
  endtask

  task automatic test_reset_mid_settle();
    do_reset('0);
    edge1();
    SW_raw = 5'b00100;
    repeat (7) edge1();
    SW_raw = 5'b00011;
    repeat (4) edge1();
    Resetn = 1'b0;
    #1;
    n_total++;
    if (SW_out !== 5'b0 || SW_valid !== 1'b0 || SW_changed !== 5'b0) begin
      n_bad++;
      $display("FAIL async_reset got out=%b valid=%b chg=%b want 00000/0/00000",
               SW_out, SW_valid, SW_changed);
    end
    edge1();
    edge1();
    n_total++;
    if (SW_out !== 5'b0 || SW_valid !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_held got out=%b valid=%b want 00000/0", SW_out, SW_valid);
    end
    Resetn = 1'b1;
    for (int i = 0; i < 6; i++) begin
      edge1();
      n_total++;
      if (SW_valid !== 1'b0 || SW_out !== 5'b0) begin
        n_bad++;
        $display("FAIL post_reset_early E%0d got out=%b valid=%b want 00000/0",
                 i, SW_out, SW_valid);
      end
    end
    edge1();
    n_total++;
    if (SW_out !== 5'b00011 || SW_valid !== 1'b1 || SW_changed !== 5'b00011) begin
      n_bad++;
      $display("FAIL post_reset_commit got out=%b valid=%b chg=%b want 00011/1/00011",
               SW_out, SW_valid, SW_changed);
    end
  endtask

  initial begin
    n_total = 0;
    n_bad   = 0;
    Resetn  = 1'b0;
    SW_raw  = '0;
    SW_ack  = 1'b0;
    test_reset();
    test_basic_commit();
    test_bounce_low();
    test_bounce_high();
    test_accumulate();
    test_collision();
    test_reset_mid_settle();
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

// File: doc/sw_input_conditioner.md
Name: sw_input_conditioner

Overview:
- Input-side peripheral that produces the processor's SW_in bus from raw board switches.
- Per bit: two-flop synchronizer. Whole vector: one debounce FSM and counter.
- A new value is committed to SW_out only after it has been stable for DEBOUNCE_CYCLES consecutive clocks.
- Each commit raises a sticky change event; the processor clears it with a valid/ack handshake.

Parameters:
- WIDTH, 5: number of switch bits; matches the processor SW_in width.
- DEBOUNCE_CYCLES, 16: consecutive stable clocks required before a commit. Legal range 1..(2^CNT_W - 1).
- CNT_W, 8: width of the debounce counter.

Ports:
- Clock  in  1  system clock; all state changes on the rising edge.
- Resetn  in  1  reset, active-low, asynchronous assert, applied to every flop.
- SW_raw  in  WIDTH  raw switch levels; asynchronous to Clock; may bounce.
- SW_ack  in  1  processor acknowledge; clears the pending change event.
- SW_out  out  WIDTH  debounced switch value; connects to processor SW_in.
- SW_valid  out  1  change event pending; held high until acknowledged.
- SW_changed  out  WIDTH  mask of bits that changed since the last acknowledge.

Behaviour:
- Reset (Resetn=0, asynchronous): sync1, sync2, cand, SW_out, SW_changed all 0; SW_valid 0; cnt 0; state STABLE.
- No output glitches while reset is held.
- Reset asserted mid-settle aborts the settle; nothing is committed.
- Switches that are high when reset releases debounce normally and produce a change event (SW_changed = their mask).
- Synchronizer: sync1 <= SW_raw; sync2 <= sync1. The FSM uses only sync2.
- State STABLE:
  - sync2 == SW_out: hold.
  - sync2 != SW_out: cand <= sync2, cnt <= 0, go to SETTLE.
- State SETTLE:
  - sync2 == cand and cnt == DEBOUNCE_CYCLES-1: commit, then go to STABLE.
  - sync2 == cand otherwise: cnt <= cnt+1.
  - sync2 != cand and sync2 == SW_out (bounce back): cnt <= 0, go to STABLE; no commit.
  - sync2 != cand and sync2 != SW_out: cand <= sync2, cnt <= 0, stay in SETTLE.
- With DEBOUNCE_CYCLES=1 the commit occurs on the first SETTLE cycle.
- Commit:
  - SW_out <= cand.
  - SW_valid <= 1.
  - SW_changed <= (SW_valid ? SW_changed : 0) | (SW_out ^ cand).
  - A commit while SW_valid is already 1 accumulates the mask; SW_valid stays 1.
- Latency: raw changes before edge E0. The FSM sees the change at E2; SW_out and SW_valid update at edge E(DEBOUNCE_CYCLES+2). That is the (DEBOUNCE_CYCLES+3)th edge counting E0 as the first.
- Acknowledge:
  - SW_ack=1 with SW_valid=1 and no commit that cycle: SW_valid <= 0, SW_changed <= 0.
  - SW_ack with SW_valid=0 is ignored.
- Ack and commit in the same cycle: the commit wins. SW_valid stays 1; SW_changed <= SW_out ^ cand only, because the old mask was consumed by the ack.
- SW_out changes only on a commit; it is never driven from sync1 or sync2 directly.
- cnt never exceeds DEBOUNCE_CYCLES-1, so there is no wrap.

Test Plan:
1. Reset then idle, SW_raw=0 for 20 clocks -> SW_out=0, SW_valid=0, SW_changed=0 throughout.
2. DEBOUNCE_CYCLES=4: SW_raw 0->5'b00101 before E0 -> SW_out=5'b00101, SW_valid=1, SW_changed=5'b00101 at E6, not earlier. Then SW_ack for 1 clock -> SW_valid=0, SW_changed=0.
3. Bounce: SW_raw toggles bit0 1,0,1,0 on successive clocks, then stays 0 -> no commit; SW_valid stays 0.
4. Bounce: as scenario 3 but ending at 1 -> a single commit 4 clocks after the last toggle is seen in sync2; SW_changed=5'b00001.
5. Accumulate: commit 5'b00001, no ack, then raw 5'b10001 -> SW_out=5'b10001, SW_changed=5'b10001, SW_valid=1 throughout.
6. Collision: pulse SW_ack on the exact cycle of the second commit -> SW_valid=1, SW_changed=5'b10000.
7. Reset mid-settle: Resetn=0 during SETTLE -> all outputs 0 immediately (asynchronous). After release with raw=5'b00011 -> commit 5'b00011 at DEBOUNCE_CYCLES+3 edges after release.
